// File: rtl/adc_csr_init_sequencer.sv
// rtl/adc_csr_init_sequencer.sv - power-up CSR write sequencer for the modular ADC with verify, retry and timeout
module adc_csr_init_sequencer #(
    parameter int                           DELAY_CYCLES   = 5,
    parameter int                           NUM_WRITES     = 1,
    parameter int                           ADDR_W         = 1,
    parameter logic [NUM_WRITES*ADDR_W-1:0] WR_ADDR        = '0,
    parameter logic [NUM_WRITES*32-1:0]     WR_DATA        = 32'h00000001,
    parameter int                           VERIFY         = 0,
    parameter logic [31:0]                  VERIFY_MASK    = 32'hFFFFFFFF,
    parameter int                           MAX_RETRIES    = 2,
    parameter int                           TIMEOUT_CYCLES = 64
) (
    input  logic              Clock_qsys,
    input  logic              Reset_n,
    output logic [ADDR_W-1:0] AdcCsrAddress,
    output logic              AdcCsrReadEn,
    input  logic [31:0]       AdcCsrReadData,
    output logic              AdcCsrWriteEn,
    output logic [31:0]       AdcCsrWriteData,
    input  logic              AdcCsrWaitRequest,
    input  logic              Restart,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    // Counter widths; each is at least one bit so degenerate parameters still elaborate.
    localparam int DW = (DELAY_CYCLES > 1)   ? $clog2(DELAY_CYCLES)    : 1;
    localparam int IW = (NUM_WRITES > 1)     ? $clog2(NUM_WRITES)      : 1;
    localparam int RW = (MAX_RETRIES > 0)    ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_WRITES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_RESET,
        S_DELAY,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     delay_q, delay_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     tmo_q,   tmo_d;

    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_data;
    logic              tmo_hit;
    logic              rd_match;

    // Look up the current list entry's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_WRITES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_addr = WR_ADDR[i*ADDR_W +: ADDR_W];
                sel_data = WR_DATA[i*32 +: 32];
            end
        end
    end

    // A stalled cycle that would be the TIMEOUT_CYCLES-th consecutive one aborts the sequence.
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
    assign rd_match = ((AdcCsrReadData ^ sel_data) & VERIFY_MASK) == 32'h0;

    // Next-state logic; the stall counter defaults to clear so any exit or acceptance resets it.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        tmo_d   = '0;
        unique case (state_q)
            S_RESET: begin
                state_d = S_DELAY;
                delay_d = DELAY_LOAD;
                idx_d   = '0;
                retry_d = '0;
            end
            S_DELAY: begin
                if (delay_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            S_WRITE: begin
                if (AdcCsrWaitRequest) begin
                    if (tmo_hit) begin
                        state_d = S_ERROR;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else if (VERIFY != 0) begin
                    state_d = S_READ;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_READ: begin
                if (AdcCsrWaitRequest) begin
                    if (tmo_hit) begin
                        state_d = S_ERROR;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rd_match) begin
                    retry_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_WRITE;
                    end
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (Restart) begin
                    state_d = S_DELAY;
                    delay_d = DELAY_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // Moore output decode from the registered state and entry index.
    always_comb begin
        AdcCsrAddress   = '0;
        AdcCsrReadEn    = 1'b0;
        AdcCsrWriteEn   = 1'b0;
        AdcCsrWriteData = 32'h0;
        Busy            = 1'b1;
        Done            = 1'b0;
        Error           = 1'b0;
        case (state_q)
            S_WRITE: begin
                AdcCsrWriteEn   = 1'b1;
                AdcCsrAddress   = sel_addr;
                AdcCsrWriteData = sel_data;
            end
            S_READ: begin
                AdcCsrReadEn  = 1'b1;
                AdcCsrAddress = sel_addr;
            end
            S_DONE: begin
                Busy = 1'b0;
                Done = 1'b1;
            end
            S_ERROR: begin
                Busy  = 1'b0;
                Error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge Clock_qsys) begin
        if (!Reset_n) begin
            state_q <= S_RESET;
            delay_q <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_adc_csr_init_sequencer.sv
// tb/tb_adc_csr_init_sequencer.sv - self-checking bench for adc_csr_init_sequencer
module tb_adc_csr_init_sequencer;

    localparam int DEF_DELAY = 5;
    localparam int V_DELAY   = 3;
    localparam int V_MAXR    = 2;
    localparam int V_TMO     = 4;
    localparam int BUDGET    = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rstn_a = 1'b0, restart_a = 1'b0, wait_a = 1'b0;
    logic [31:0] rdata_a = 32'h0;
    logic [0:0]  addr_a;
    logic        rd_a, wr_a, busy_a, done_a, err_a;
    logic [31:0] wdata_a;

    // Three-entry verifying instance
    logic        rstn_b = 1'b0, restart_b = 1'b0, wait_b = 1'b0;
    logic [31:0] rdata_b = 32'h0;
    logic [1:0]  addr_b;
    logic        rd_b, wr_b, busy_b, done_b, err_b;
    logic [31:0] wdata_b;

    adc_csr_init_sequencer u_def (
        .Clock_qsys        (clk),
        .Reset_n           (rstn_a),
        .AdcCsrAddress     (addr_a),
        .AdcCsrReadEn      (rd_a),
        .AdcCsrReadData    (rdata_a),
        .AdcCsrWriteEn     (wr_a),
        .AdcCsrWriteData   (wdata_a),
        .AdcCsrWaitRequest (wait_a),
        .Restart           (restart_a),
        .Busy              (busy_a),
        .Done              (done_a),
        .Error             (err_a)
    );

    adc_csr_init_sequencer #(
        .DELAY_CYCLES   (V_DELAY),
        .NUM_WRITES     (3),
        .ADDR_W         (2),
        .WR_ADDR        (6'b11_01_10),
        .WR_DATA        ({32'hCAFE0003, 32'h0000A5A5, 32'h12345678}),
        .VERIFY         (1),
        .VERIFY_MASK    (32'hFFFFFFFF),
        .MAX_RETRIES    (V_MAXR),
        .TIMEOUT_CYCLES (V_TMO)
    ) u_ver (
        .Clock_qsys        (clk),
        .Reset_n           (rstn_b),
        .AdcCsrAddress     (addr_b),
        .AdcCsrReadEn      (rd_b),
        .AdcCsrReadData    (rdata_b),
        .AdcCsrWriteEn     (wr_b),
        .AdcCsrWriteData   (wdata_b),
        .AdcCsrWaitRequest (wait_b),
        .Restart           (restart_b),
        .Busy              (busy_b),
        .Done              (done_b),
        .Error             (err_b)
    );

    // Entry list of u_ver as the bench understands it
    logic [1:0]  v_addr [3] = '{2'd2, 2'd1, 2'd3};
    logic [31:0] v_data [3] = '{32'h12345678, 32'h0000A5A5, 32'hCAFE0003};

    int n_vec = 0;
    int n_err = 0;

    // Slave model state for u_ver
    logic [31:0] mem [4];
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    bit          exp_err;
    int          corrupt_left = 0;
    bit          stall_rnd = 1'b0;
    bit          force_wait_b = 1'b0;
    bit          armed_b = 1'b0;
    int          stall_left_b = 0;
    bit          stalled_b = 1'b0;
    bit          rd_acc_prev = 1'b0;
    logic [34:0] held_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, check u_ver bus rules, then play the slave.
    task automatic tick();
        logic [31:0] v;
        bit          rd_acc;
        @(negedge clk);
        restart_a = 1'b0;
        restart_b = 1'b0;
        if (rd_b || wr_b) chk("strobe_excl", rd_b & wr_b, 0);
        if (stalled_b && (rd_b || wr_b)) chk("stall_hold", {wr_b, addr_b, wdata_b}, held_b);
        if (force_wait_b) begin
            wait_b = 1'b1;
        end else if (rd_b || wr_b) begin
            if (!armed_b) begin
                stall_left_b = stall_rnd ? int'($urandom_range(0, 3)) : 2;
                armed_b = 1'b1;
            end
            wait_b = (stall_left_b > 0);
            if (stall_left_b > 0) stall_left_b--;
        end else begin
            wait_b  = 1'($urandom_range(0, 1));
            armed_b = 1'b0;
        end
        stalled_b = (rd_b || wr_b) && wait_b;
        held_b    = {wr_b, addr_b, wdata_b};
        rd_acc    = rd_b && !wait_b;
        if (wr_b && !wait_b) begin
            mem[addr_b] = wdata_b;
            obs_q.push_back({4'h1, 4'(addr_b), wdata_b});
            armed_b = 1'b0;
        end
        if (rd_acc) begin
            v = mem[addr_b];
            if (addr_b == v_addr[0] && corrupt_left > 0) begin
                v = 32'h0;
                corrupt_left--;
            end
            rdata_b = v;
            obs_q.push_back({4'h0, 4'(addr_b), 32'h0});
            armed_b = 1'b0;
        end else if (!rd_acc_prev) begin
            rdata_b = $urandom;
        end
        rd_acc_prev = rd_acc;
    endtask

    // Transaction-level expectation: entry 0 fails its first k read-backs.
    task automatic build_exp(input int k);
        int fails, tries;
        exp_q.delete();
        exp_err = 1'b0;
        for (int e = 0; e < 3; e++) begin
            if (!exp_err) begin
                fails = (e == 0) ? k : 0;
                tries = (fails > V_MAXR) ? V_MAXR + 1 : fails + 1;
                for (int t = 0; t < tries; t++) begin
                    exp_q.push_back({4'h1, 4'(v_addr[e]), v_data[e]});
                    exp_q.push_back({4'h0, 4'(v_addr[e]), 32'h0});
                end
                if (fails > V_MAXR) exp_err = 1'b1;
            end
        end
    endtask

    task automatic run_ver(input string tag, input bit rnd, input int k);
        int cyc;
        int quiet;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        corrupt_left = k;
        stall_rnd    = rnd;
        obs_q.delete();
        build_exp(k);
        tick();
        chk({tag, "_busy_start"}, busy_b, 1);
        cyc = 1;
        while (!(done_b || err_b) && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        chk({tag, "_in_budget"}, cyc < BUDGET, 1);
        chk({tag, "_n_xfers"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_xfer%0d", tag, i), obs_q[i], exp_q[i]);
        chk({tag, "_done"}, done_b, !exp_err);
        chk({tag, "_error"}, err_b, exp_err);
        chk({tag, "_busy_end"}, busy_b, 0);
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_b || wr_b) quiet++;
        end
        chk({tag, "_quiet_after"}, quiet, 0);
        chk({tag, "_sticky"}, {done_b, err_b}, {!exp_err, exp_err});
    endtask

    // Default instance: write in cycle DELAY+1 after the release edge, Done from the next.
    task automatic def_timing(input string tag);
        for (int n = 1; n <= DEF_DELAY + 4; n++) begin
            tick();
            chk($sformatf("%s_wr_c%0d", tag, n), wr_a, n == DEF_DELAY + 1);
            chk($sformatf("%s_rd_c%0d", tag, n), rd_a, 0);
            if (n == DEF_DELAY + 1) chk({tag, "_wr_bus"}, {addr_a, wdata_a}, {1'b0, 32'h00000001});
            else chk($sformatf("%s_idle_bus_c%0d", tag, n), {addr_a, wdata_a}, 0);
            chk($sformatf("%s_busy_c%0d", tag, n), busy_a, n < DEF_DELAY + 2);
            chk($sformatf("%s_done_c%0d", tag, n), done_a, n >= DEF_DELAY + 2);
            chk($sformatf("%s_err_c%0d", tag, n), err_a, 0);
        end
    endtask

    initial begin
        int wr_cnt;
        int k;

        // Reset state of both instances
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        repeat (3) tick();
        chk("rst_a", {addr_a, rd_a, wr_a, wdata_a, busy_a, done_a, err_a}, {1'b0, 2'b00, 32'h0, 3'b100});
        chk("rst_b", {addr_b, rd_b, wr_b, wdata_b, busy_b, done_b, err_b}, {2'b00, 2'b00, 32'h0, 3'b100});

        // Default boot, then restart from DONE with identical timing
        rstn_a = 1'b1;
        def_timing("boot");
        restart_a = 1'b1;
        def_timing("restart");

        // Reset during a stalled write aborts and the sequence replays from scratch
        restart_a = 1'b1;
        wait_a    = 1'b1;
        repeat (DEF_DELAY + 2) tick();
        chk("mid_stalled_wr", {wr_a, addr_a, wdata_a, done_a}, {1'b1, 1'b0, 32'h1, 1'b0});
        rstn_a = 1'b0;
        tick();
        chk("mid_rst_state", {addr_a, rd_a, wr_a, wdata_a, busy_a, done_a, err_a}, {1'b0, 2'b00, 32'h0, 3'b100});
        rstn_a = 1'b1;
        wait_a = 1'b0;
        def_timing("after_rst");

        // Verifying instance: fixed 2-cycle stalls, echoing slave
        rstn_b = 1'b1;
        run_ver("fixed", 1'b0, 0);

        // Retries exhausted, then recovery from ERROR via Restart
        restart_b = 1'b1;
        run_ver("exhaust", 1'b1, V_MAXR + 1);
        restart_b = 1'b1;
        run_ver("retry1", 1'b1, 1);
        for (int r = 0; r < 5; r++) begin
            k = int'($urandom_range(0, 3));
            restart_b = 1'b1;
            run_ver($sformatf("rnd%0d_k%0d", r, k), 1'b1, k);
        end

        // Timeout: waitrequest held high keeps the write strobe up for TIMEOUT_CYCLES cycles
        restart_b    = 1'b1;
        force_wait_b = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 60 && !err_b; i++) begin
            tick();
            if (wr_b) wr_cnt++;
        end
        chk("tmo_wr_cycles", wr_cnt, V_TMO);
        chk("tmo_state", {err_b, done_b, busy_b, wr_b, rd_b}, 5'b10000);
        force_wait_b = 1'b0;
        restart_b = 1'b1;
        run_ver("post_tmo", 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
